tile_sequencer: RTL and testbench

Top-level tile scheduler for the systolic-array matmul. On a `start` pulse it walks every output submatrix (m outer, n middle, k inner). For each k step it runs one compute pass on the array and waits for it to finish. After the last k of each (m,n) tile it launches the output-store controller to drain and clear the accumulators, with partial-tile row/column counts and a running write address. It sits between the host command registers and the compute/output-store controllers, and it is the only block that drives their start strobes.

---
 rtl/tile_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_tile_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_sequencer.sv
// tile_sequencer: top-level tile scheduler for the systolic-array matmul.
// Walks every output submatrix (m outer, n middle, k inner). It runs one
// compute pass per k step. After the last k of each (m,n) tile it launches
// the output-store controller, passing the partial-tile sizes and a running
// write address.
// Optional feature macro: TILE_SEQ_PERF_CNT_EN adds the perf_cycles and
// perf_stores counters.
module tile_sequencer #(
    parameter  int MAX_OUT_ROWS = 128,
    parameter  int MAX_OUT_COLS = 128,
    parameter  int MAX_K_TILES  = 8,
    parameter  int SYS_ARR_ROWS = 16,
    parameter  int SYS_ARR_COLS = 16,
    parameter  int ADDR_WIDTH   = 8,
    localparam int MW = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS),
    localparam int NW = $clog2(MAX_OUT_COLS / SYS_ARR_COLS),
    localparam int KW = $clog2(MAX_K_TILES),
    localparam int RW = $clog2(SYS_ARR_ROWS),
    localparam int CW = $clog2(SYS_ARR_COLS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [MW-1:0]         cfg_m_tiles,
    input  logic [NW-1:0]         cfg_n_tiles,
    input  logic [KW-1:0]         cfg_k_tiles,
    input  logic [RW-1:0]         cfg_last_rows,
    input  logic [CW-1:0]         cfg_last_cols,
    input  logic                  cfg_activate,
    input  logic [ADDR_WIDTH-1:0] cfg_out_base,
    output logic                  comp_start,
    input  logic                  comp_done,
    output logic [MW-1:0]         comp_submat_row,
    output logic [NW-1:0]         comp_submat_col,
    output logic [KW-1:0]         comp_submat_k,
    output logic                  out_start,
    input  logic                  out_done,
    output logic [MW-1:0]         out_submat_row,
    output logic [NW-1:0]         out_submat_col,
    output logic [RW-1:0]         out_num_rows_read,
    output logic [CW-1:0]         out_num_cols_read,
    output logic                  out_activate,
    output logic                  out_clear_after,
    output logic [ADDR_WIDTH-1:0] out_wr_base_addr
`ifdef TILE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [15:0]           perf_stores
`endif
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_COMP       = 3'd1;
    localparam logic [2:0] S_COMP_WAIT  = 3'd2;
    localparam logic [2:0] S_STORE      = 3'd3;
    localparam logic [2:0] S_STORE_WAIT = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    logic [2:0]            state, state_next;
    logic [MW-1:0]         m_idx, lat_m;
    logic [NW-1:0]         n_idx, lat_n;
    logic [KW-1:0]         k_idx, lat_k;
    logic [RW-1:0]         lat_rows;
    logic [CW-1:0]         lat_cols;
    logic                  lat_act;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last_k;
    logic                  last_n;
    logic                  last_m;

    assign last_k = (k_idx == lat_k);
    assign last_n = (n_idx == lat_n);
    assign last_m = (m_idx == lat_m);

    // Next-state decode for the tile walk.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:       if (start) state_next = S_COMP;
            S_COMP:       state_next = S_COMP_WAIT;
            S_COMP_WAIT:  if (comp_done) state_next = last_k ? S_STORE : S_COMP;
            S_STORE:      state_next = S_STORE_WAIT;
            S_STORE_WAIT: if (out_done) state_next = (last_m && last_n) ? S_DONE : S_COMP;
            S_DONE:       state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    // State, latched job configuration, tile indices and write address.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= S_IDLE;
            m_idx    <= '0;
            n_idx    <= '0;
            k_idx    <= '0;
            lat_m    <= '0;
            lat_n    <= '0;
            lat_k    <= '0;
            lat_rows <= '0;
            lat_cols <= '0;
            lat_act  <= 1'b0;
            addr     <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lat_m    <= cfg_m_tiles;
                        lat_n    <= cfg_n_tiles;
                        lat_k    <= cfg_k_tiles;
                        lat_rows <= cfg_last_rows;
                        lat_cols <= cfg_last_cols;
                        lat_act  <= cfg_activate;
                        addr     <= cfg_out_base;
                        m_idx    <= '0;
                        n_idx    <= '0;
                        k_idx    <= '0;
                    end
                end
                S_COMP_WAIT: begin
                    if (comp_done && !last_k) k_idx <= k_idx + KW'(1);
                end
                S_STORE_WAIT: begin
                    if (out_done) begin
                        k_idx <= '0;
                        addr  <= addr + ADDR_WIDTH'(SYS_ARR_ROWS);
                        if (last_n) begin
                            n_idx <= '0;
                            // m wraps back to 0 once the final tile row is stored.
                            m_idx <= last_m ? '0 : m_idx + MW'(1);
                        end else begin
                            n_idx <= n_idx + NW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and status decode directly from the registered state.
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_DONE);
    assign comp_start      = (state == S_COMP);
    assign out_start       = (state == S_STORE);
    assign out_clear_after = out_start;

    assign comp_submat_row  = m_idx;
    assign comp_submat_col  = n_idx;
    assign comp_submat_k    = k_idx;
    assign out_submat_row   = m_idx;
    assign out_submat_col   = n_idx;
    assign out_activate     = lat_act;
    assign out_wr_base_addr = addr;

    // Partial tiles only occur in the last tile row / column.
    assign out_num_rows_read = last_m ? lat_rows : RW'(SYS_ARR_ROWS - 1);
    assign out_num_cols_read = last_n ? lat_cols : CW'(SYS_ARR_COLS - 1);

`ifdef TILE_SEQ_PERF_CNT_EN
    // Busy-cycle counter (saturating) and store counter, cleared per job.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_stores <= '0;
        end else if (state == S_IDLE && start) begin
            perf_cycles <= '0;
            perf_stores <= '0;
        end else begin
            if (busy && perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'd1;
            if (out_start) perf_stores <= perf_stores + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// Self-checking bench for tile_sequencer. A behavioural model expands each
// job into the expected ordered list of compute passes and stores, and a
// responder emulates the compute and store engines with random latencies.
module tb_tile_sequencer;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done;
    logic [2:0] cfg_m_tiles, cfg_n_tiles, cfg_k_tiles;
    logic [3:0] cfg_last_rows, cfg_last_cols;
    logic       cfg_activate;
    logic [7:0] cfg_out_base;
    logic       comp_start, comp_done;
    logic [2:0] comp_submat_row, comp_submat_col, comp_submat_k;
    logic       out_start, out_done;
    logic [2:0] out_submat_row, out_submat_col;
    logic [3:0] out_num_rows_read, out_num_cols_read;
    logic       out_activate, out_clear_after;
    logic [7:0] out_wr_base_addr;

    tile_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles),
        .cfg_last_rows(cfg_last_rows), .cfg_last_cols(cfg_last_cols),
        .cfg_activate(cfg_activate), .cfg_out_base(cfg_out_base),
        .comp_start(comp_start), .comp_done(comp_done),
        .comp_submat_row(comp_submat_row), .comp_submat_col(comp_submat_col),
        .comp_submat_k(comp_submat_k),
        .out_start(out_start), .out_done(out_done),
        .out_submat_row(out_submat_row), .out_submat_col(out_submat_col),
        .out_num_rows_read(out_num_rows_read), .out_num_cols_read(out_num_cols_read),
        .out_activate(out_activate), .out_clear_after(out_clear_after),
        .out_wr_base_addr(out_wr_base_addr)
    );

    always #5 clk = ~clk;

    typedef struct { int m; int n; int k; } comp_t;
    typedef struct { int m; int n; int rows; int cols; int addr; int act; } store_t;

    comp_t  comp_q[$];
    store_t store_q[$];

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    int busy_cycles = 0;
    int cyc = 0;
    bit fast = 1'b0;      // zero-latency engines
    bit comp_hold = 1'b0; // compute engine stalls for a long time
    bit hold_req = 1'b0;  // store engine stalls 20 cycles on the next store
    bit hold_meas = 1'b0; // measure the gap after the next store
    bit hold_armed = 1'b0;
    int hold_t0 = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected sequence of compute passes and stores for one job.
    task automatic plan(input int mt, input int nt, input int kt, input int lr,
                        input int lc, input int act, input int base);
        int idx;
        idx = 0;
        for (int m = 0; m <= mt; m++) begin
            for (int n = 0; n <= nt; n++) begin
                store_t s;
                for (int k = 0; k <= kt; k++) comp_q.push_back('{m: m, n: n, k: k});
                s.m    = m;
                s.n    = n;
                s.rows = (m == mt) ? lr : ROWS - 1;
                s.cols = (n == nt) ? lc : COLS - 1;
                s.addr = (base + ROWS * idx) % 256;
                s.act  = act;
                store_q.push_back(s);
                idx++;
            end
        end
    endtask

    // Engine emulation: drop done on the strobe, raise it after a latency.
    initial begin
        int comp_cnt, out_cnt;
        comp_cnt = -1;
        out_cnt = -1;
        comp_done = 1'b1;
        out_done = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                comp_done = 1'b1;
                out_done = 1'b1;
                comp_cnt = -1;
                out_cnt = -1;
            end else begin
                if (comp_cnt > 0) comp_cnt--;
                else if (comp_cnt == 0) begin comp_done = 1'b1; comp_cnt = -1; end
                if (out_cnt > 0) out_cnt--;
                else if (out_cnt == 0) begin out_done = 1'b1; out_cnt = -1; end
                if (comp_start) begin
                    comp_done = 1'b0;
                    comp_cnt = comp_hold ? 1000 : (fast ? 0 : int'($urandom_range(0, 3)));
                end
                if (out_start) begin
                    out_done = 1'b0;
                    if (hold_req) begin out_cnt = 20; hold_req = 1'b0; end
                    else out_cnt = fast ? 0 : int'($urandom_range(0, 3));
                end
            end
        end
    end

    // Output monitor: every strobe is compared against the model queues.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cycles++;
            if (done) done_count++;
            if (hold_armed && (comp_start || done)) begin
                check("hold_gap", cyc - hold_t0, 22);
                hold_armed = 1'b0;
            end
            if (comp_start) begin
                if (comp_q.size() == 0) check("comp_extra", 1, 0);
                else begin
                    comp_t e;
                    e = comp_q.pop_front();
                    check("comp_m", int'(comp_submat_row), e.m);
                    check("comp_n", int'(comp_submat_col), e.n);
                    check("comp_k", int'(comp_submat_k), e.k);
                end
            end
            if (out_start) begin
                if (hold_meas) begin hold_armed = 1'b1; hold_t0 = cyc; hold_meas = 1'b0; end
                if (store_q.size() == 0) check("store_extra", 1, 0);
                else begin
                    store_t s;
                    s = store_q.pop_front();
                    check("out_m", int'(out_submat_row), s.m);
                    check("out_n", int'(out_submat_col), s.n);
                    check("out_rows", int'(out_num_rows_read), s.rows);
                    check("out_cols", int'(out_num_cols_read), s.cols);
                    check("out_addr", int'(out_wr_base_addr), s.addr);
                    check("out_act", int'(out_activate), s.act);
                    check("out_clear", int'(out_clear_after), 1);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_strobes"}, int'({comp_start, out_start, out_clear_after}), 0);
        check({tag, "_idx"}, int'({comp_submat_row, comp_submat_col, comp_submat_k}), 0);
        check({tag, "_outidx"}, int'({out_submat_row, out_submat_col}), 0);
        check({tag, "_sizes"}, int'({out_num_rows_read, out_num_cols_read}), 0);
        check({tag, "_addr_act"}, int'({out_wr_base_addr, out_activate}), 0);
    endtask

    // One complete job: program, launch, optionally disturb, wait for done.
    task automatic run_job(input int mt, input int nt, input int kt, input int lr,
                           input int lc, input int act, input int base, input bit poke);
        int expect_cycles;
        @(negedge clk);
        cfg_m_tiles = 3'(mt);
        cfg_n_tiles = 3'(nt);
        cfg_k_tiles = 3'(kt);
        cfg_last_rows = 4'(lr);
        cfg_last_cols = 4'(lc);
        cfg_activate = act[0];
        cfg_out_base = 8'(base);
        plan(mt, nt, kt, lr, lc, act, base);
        done_count = 0;
        busy_cycles = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("launch_comp_start", int'(comp_start), 1);
        check("launch_busy", int'(busy), 1);
        if (poke) begin
            // Mid-job cfg changes must not affect the latched job.
            cfg_m_tiles = 3'($urandom);
            cfg_n_tiles = 3'($urandom);
            cfg_k_tiles = 3'($urandom);
            cfg_last_rows = 4'($urandom);
            cfg_last_cols = 4'($urandom);
            cfg_activate = ~act[0];
            cfg_out_base = 8'($urandom);
        end
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (done_count != 0) break;
            if (poke) start = (i == 4);
        end
        start = 1'b0;
        check("job_done_seen", done_count, 1);
        @(negedge clk);
        #1;
        check("done_once", done_count, 1);
        check("idle_after", int'(busy), 0);
        check("comp_left", comp_q.size(), 0);
        check("store_left", store_q.size(), 0);
        if (fast) begin
            expect_cycles = 2 * ((kt + 1) * (mt + 1) * (nt + 1)) + 2 * ((mt + 1) * (nt + 1)) + 1;
            check("job_cycles", busy_cycles, expect_cycles);
        end
        comp_q.delete();
        store_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cfg_m_tiles = '0;
        cfg_n_tiles = '0;
        cfg_k_tiles = '0;
        cfg_last_rows = '0;
        cfg_last_cols = '0;
        cfg_activate = 1'b0;
        cfg_out_base = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single-tile job with zero-latency engines.
        fast = 1'b1;
        run_job(0, 0, 0, 0, 0, 1, 8'h3C, 1'b0);
        // 2x3 tiles, 3 k steps each.
        run_job(1, 2, 2, 15, 15, 0, 0, 1'b0);
        // Partial last row / column sizes.
        run_job(1, 1, 1, 4, 9, 1, 8'h20, 1'b0);
        // Address wraparound.
        run_job(0, 1, 0, 7, 3, 0, 8'hF0, 1'b0);

        // Store engine stalls 20 cycles on the first store.
        fast = 1'b0;
        hold_req = 1'b1;
        hold_meas = 1'b1;
        run_job(0, 1, 1, 2, 5, 1, 8'h10, 1'b0);

        // Spurious start and cfg changes while busy.
        run_job(1, 1, 2, 6, 11, 1, 8'h44, 1'b1);

        // Reset asserted while waiting for the compute engine.
        @(negedge clk);
        cfg_m_tiles = 3'd1;
        cfg_n_tiles = 3'd1;
        cfg_k_tiles = 3'd1;
        cfg_last_rows = 4'd3;
        cfg_last_cols = 4'd3;
        cfg_activate = 1'b1;
        cfg_out_base = 8'h80;
        comp_q.push_back('{m: 0, n: 0, k: 0});
        comp_hold = 1'b1;
        done_count = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("stall_wait_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("midreset");
        reset = 1'b0;
        comp_hold = 1'b0;
        comp_q.delete();
        store_q.delete();
        repeat (10) @(negedge clk);
        #1;
        check("midreset_no_done", done_count, 0);
        check("midreset_idle", int'(busy), 0);
        run_job(1, 0, 1, 9, 2, 0, 8'h08, 1'b0);

        // Randomized jobs with random engine latencies.
        for (int j = 0; j < 10; j++) begin
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 255)), j[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
